// File: rtl/maria_dl_pkg.sv
// Maria display-list fetch: shared state type and header field layout.
// Optional character (indirect) mode is enabled by MARIA_DL_INDIRECT_EN.
package maria_dl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DECODE,
    S_GFX,
    S_CHR,
    S_EMIT,
    S_FIN
  } state_t;

  localparam int WM_BIT    = 7;
  localparam int EXT_BIT   = 6;
  localparam int IND_BIT   = 5;
  localparam int PAL_MSB   = 7;
  localparam int PAL_LSB   = 5;
  localparam int WIDTH_MSB = 4;
  localparam int WIDTH_LSB = 0;

  localparam logic [2:0] HDR_LEN4 = 3'd4;
  localparam logic [2:0] HDR_LEN5 = 3'd5;

  // A width code of zero encodes the widest object, 32 bytes.
  function automatic logic [5:0] obj_width(input logic [4:0] wcode);
    return (wcode == 5'd0) ? 6'd32 : 6'd32 - {1'b0, wcode};
  endfunction

endpackage

// File: rtl/maria_dl_hdr_decode.sv
// Maria display-list fetch: combinational 4/5-byte object header decode.
// The ind flag is only honoured when MARIA_DL_INDIRECT_EN is defined.
module maria_dl_hdr_decode
  import maria_dl_pkg::*;
(
  input  logic [7:0] hb0,
  input  logic [7:0] hb1,
  input  logic [7:0] hb2,
  input  logic [7:0] hb3,
  input  logic [7:0] hb4,
  output logic       is_end,
  output logic       is_ext,
  output logic [7:0] lo,
  output logic [7:0] hi,
  output logic [2:0] palette,
  output logic [5:0] width,
  output logic [7:0] hpos,
  output logic       wm_new,
  output logic       wm_load,
  output logic       ind
);

  logic [4:0] wcode;

  assign is_end  = (hb1[6:0] == 7'd0);
  assign is_ext  = (hb1[WIDTH_MSB:WIDTH_LSB] == 5'd0) && hb1[EXT_BIT];
  assign lo      = hb0;
  assign hi      = hb2;
  assign palette = is_ext ? hb3[PAL_MSB:PAL_LSB] : hb1[PAL_MSB:PAL_LSB];
  assign wcode   = is_ext ? hb3[WIDTH_MSB:WIDTH_LSB]
                          : hb1[WIDTH_MSB:WIDTH_LSB];
  assign width   = obj_width(wcode);
  assign hpos    = is_ext ? hb4 : hb3;
  assign wm_new  = hb1[WM_BIT];
  assign wm_load = is_ext;
  assign ind     = is_ext && hb1[IND_BIT];

endmodule

// File: rtl/maria_dl_fetch.sv
// Maria display-list object fetcher feeding the line-RAM writer.
// Define MARIA_DL_INDIRECT_EN to enable character (indirect) objects.
module maria_dl_fetch
  import maria_dl_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       dl_addr,
  input  logic [3:0]        zone_offset,
  input  logic [7:0]        charbase,
  input  logic              abort,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        hpos,
  output logic [2:0]        palette,
  output logic [7:0]        pixels,
  output logic              wm,
  output logic              latch_byte,
  output logic              clear_hpos,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  state_t      state;
  logic [15:0] ptr;
  logic [2:0]  hdr_idx;
  logic [7:0]  hb [5];
  logic [7:0]  lo;
  logic [7:0]  hi;
  logic [5:0]  width;
  logic [5:0]  idx;

  logic        d_is_end;
  logic        d_is_ext;
  logic [7:0]  d_lo;
  logic [7:0]  d_hi;
  logic [2:0]  d_palette;
  logic [5:0]  d_width;
  logic [7:0]  d_hpos;
  logic        d_wm_new;
  logic        d_wm_load;
  logic        d_ind;

  logic [2:0]  hdr_len;
  logic [15:0] hdr_addr;
  logic [7:0]  gfx_hi;
  logic [15:0] gfx_addr;

  maria_dl_hdr_decode u_dec (
    .hb0     (hb[0]),
    .hb1     (hb[1]),
    .hb2     (hb[2]),
    .hb3     (hb[3]),
    .hb4     (hb[4]),
    .is_end  (d_is_end),
    .is_ext  (d_is_ext),
    .lo      (d_lo),
    .hi      (d_hi),
    .palette (d_palette),
    .width   (d_width),
    .hpos    (d_hpos),
    .wm_new  (d_wm_new),
    .wm_load (d_wm_load),
    .ind     (d_ind)
  );

  assign hdr_len  = d_is_ext ? HDR_LEN5 : HDR_LEN4;
  assign hdr_addr = ptr + {13'd0, hdr_idx};
  assign gfx_hi   = hi + {4'd0, zone_offset};
  assign gfx_addr = {gfx_hi, lo} + {10'd0, idx};

`ifdef MARIA_DL_INDIRECT_EN
  logic        ind;
  logic [7:0]  data;
  logic [15:0] chr_addr;

  assign chr_addr = {charbase + {4'd0, zone_offset}, data};
`else
  logic unused_chr;

  assign unused_chr = ^{charbase, d_ind};
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      hdr_idx    <= '0;
      for (int k = 0; k < 5; k++) hb[k] <= '0;
      lo         <= '0;
      hi         <= '0;
      width      <= '0;
      idx        <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      hpos       <= '0;
      palette    <= '0;
      pixels     <= '0;
      wm         <= 1'b0;
      latch_byte <= 1'b0;
      clear_hpos <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
`ifdef MARIA_DL_INDIRECT_EN
      ind        <= 1'b0;
      data       <= '0;
`endif
    end else begin
      latch_byte <= 1'b0;
      clear_hpos <= 1'b0;
      done       <= 1'b0;
      if (abort && state != S_IDLE && state != S_FIN) begin
        state   <= S_FIN;
        mem_req <= 1'b0;
        done    <= 1'b1;
        aborted <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              ptr     <= dl_addr;
              wm      <= 1'b0;
              aborted <= 1'b0;
              hdr_idx <= '0;
              busy    <= 1'b1;
              state   <= S_HDR;
            end
          end
          S_HDR: begin
            // hb1 is already registered by the idle cycle before byte 2.
            if (!mem_req) begin
              if (hdr_idx == 3'd2 && d_is_end) begin
                done  <= 1'b1;
                state <= S_FIN;
              end else begin
                mem_req  <= 1'b1;
                mem_addr <= ADDR_W'(hdr_addr);
              end
            end else if (mem_ack) begin
              mem_req     <= 1'b0;
              hb[hdr_idx] <= mem_rdata;
              if (hdr_idx == hdr_len - 3'd1) begin
                ptr   <= ptr + {13'd0, hdr_len};
                state <= S_DECODE;
              end else begin
                hdr_idx <= hdr_idx + 3'd1;
              end
            end
          end
          S_DECODE: begin
            lo         <= d_lo;
            hi         <= d_hi;
            width      <= d_width;
            hpos       <= d_hpos;
            palette    <= d_palette;
            if (d_wm_load) wm <= d_wm_new;
`ifdef MARIA_DL_INDIRECT_EN
            ind        <= d_ind;
`endif
            idx        <= '0;
            clear_hpos <= 1'b1;
            state      <= S_GFX;
          end
          S_GFX: begin
            if (!mem_req) begin
              mem_req  <= 1'b1;
              mem_addr <= ADDR_W'(gfx_addr);
            end else if (mem_ack) begin
              mem_req <= 1'b0;
`ifdef MARIA_DL_INDIRECT_EN
              data    <= mem_rdata;
              if (ind) begin
                state <= S_CHR;
              end else begin
                pixels     <= mem_rdata;
                latch_byte <= 1'b1;
                state      <= S_EMIT;
              end
`else
              pixels     <= mem_rdata;
              latch_byte <= 1'b1;
              state      <= S_EMIT;
`endif
            end
          end
`ifdef MARIA_DL_INDIRECT_EN
          S_CHR: begin
            if (!mem_req) begin
              mem_req  <= 1'b1;
              mem_addr <= ADDR_W'(chr_addr);
            end else if (mem_ack) begin
              mem_req    <= 1'b0;
              pixels     <= mem_rdata;
              latch_byte <= 1'b1;
              state      <= S_EMIT;
            end
          end
`endif
          S_EMIT: begin
            idx <= idx + 6'd1;
            if (idx == width - 6'd1) begin
              hdr_idx <= '0;
              state   <= S_HDR;
            end else begin
              state <= S_GFX;
            end
          end
          S_FIN: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_maria_dl_fetch.sv
// Scoreboard bench for maria_dl_fetch: directed zones plus random lists.
// Expected events come from a display-list walk model over a memory array.
module tb_maria_dl_fetch;

`ifdef MARIA_DL_INDIRECT_EN
  localparam bit IND_EN = 1'b1;
`else
  localparam bit IND_EN = 1'b0;
`endif

  logic        clk_sys;
  logic        reset;
  logic        start;
  logic [15:0] dl_addr;
  logic [3:0]  zone_offset;
  logic [7:0]  charbase;
  logic        abort;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [7:0]  hpos;
  logic [2:0]  palette;
  logic [7:0]  pixels;
  logic        wm;
  logic        latch_byte;
  logic        clear_hpos;
  logic        busy;
  logic        done;
  logic        aborted;

  maria_dl_fetch #(.ADDR_W(16)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .start       (start),
    .dl_addr     (dl_addr),
    .zone_offset (zone_offset),
    .charbase    (charbase),
    .abort       (abort),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .hpos        (hpos),
    .palette     (palette),
    .pixels      (pixels),
    .wm          (wm),
    .latch_byte  (latch_byte),
    .clear_hpos  (clear_hpos),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted)
  );

  localparam logic [1:0] K_CLR = 2'd0;
  localparam logic [1:0] K_LAT = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;

  logic [7:0]  mem [65536];
  logic [21:0] q [$];
  int          checks;
  int          passes;
  int          cyc;
  int          done_cnt;
  int          lat_cnt;
  int          done_cyc;
  int          abort_cyc;
  bit          rand_wait;
  bit          abort_arm;
  logic [15:0] abort_addr;

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  always @(posedge clk_sys) cyc++;

  function automatic logic [21:0] ev(input logic [1:0] k, input logic w,
                                     input logic [2:0] p, input logic [7:0] h,
                                     input logic [7:0] x);
    return {k, w, p, h, x};
  endfunction

  task automatic push(input logic [1:0] k, input logic w, input logic [2:0] p,
                      input logic [7:0] h, input logic [7:0] x);
    q.push_back(ev(k, w, p, h, x));
  endtask

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s got=%0h want=%0h", name, got, want);
  endtask

  // Monitor: pops one expected event per output pulse.
  always @(negedge clk_sys) begin
    logic [21:0] got;
    if (!reset) begin
      if (latch_byte || clear_hpos)
        check("pulse_exclusive", 64'(latch_byte && clear_hpos), 64'd0);
      if (latch_byte || clear_hpos || done) begin
        if (latch_byte) begin
          got = ev(K_LAT, wm, palette, hpos, pixels);
          lat_cnt++;
        end else if (clear_hpos) begin
          got = ev(K_CLR, wm, palette, hpos, 8'h00);
        end else begin
          got = ev(K_DONE, 1'b0, 3'd0, 8'h00, {7'd0, aborted});
          done_cnt++;
          done_cyc = cyc;
        end
        if (q.size() == 0) check("unexpected_event", 64'(got), 64'h3fffff);
        else check("event", 64'(got), 64'(q.pop_front()));
      end
    end
  end

  // Memory responder: ack one or more cycles after the request is seen.
  initial begin
    int age;
    int need;
    age = 0;
    need = 1;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    abort = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      abort = 1'b0;
      if (mem_ack || !mem_req || reset) begin
        mem_ack = 1'b0;
        age = 0;
      end else if (age >= need) begin
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr];
        age = 0;
        need = rand_wait ? int'($urandom_range(1, 3)) : 1;
        if (abort_arm && mem_addr == abort_addr) begin
          abort = 1'b1;
          abort_arm = 1'b0;
          abort_cyc = cyc;
        end
      end else begin
        age++;
      end
    end
  end

  task automatic wr(inout logic [15:0] p, input logic [7:0] v);
    mem[p] = v;
    p = p + 16'd1;
  endtask

  // Walks the list the way the display hardware is described.
  task automatic model_zone(input logic [15:0] dl, input logic [3:0] zo,
                            input logic [7:0] cb);
    logic [15:0] p;
    logic [15:0] a;
    logic        w;
    logic        ind;
    logic [7:0]  b1, lo, hi, hp, px, ghi, chi;
    logic [2:0]  pal;
    logic [4:0]  wc;
    int          nb;
    p = dl;
    w = 1'b0;
    for (int n = 0; n < 64; n++) begin
      lo = mem[p];
      b1 = mem[16'(p + 16'd1)];
      if (b1[6:0] == 7'd0) break;
      hi = mem[16'(p + 16'd2)];
      if (b1[4:0] == 5'd0 && b1[6]) begin
        w   = b1[7];
        ind = b1[5];
        px  = mem[16'(p + 16'd3)];
        pal = px[7:5];
        wc  = px[4:0];
        hp  = mem[16'(p + 16'd4)];
        p   = 16'(p + 16'd5);
      end else begin
        ind = 1'b0;
        pal = b1[7:5];
        wc  = b1[4:0];
        hp  = mem[16'(p + 16'd3)];
        p   = 16'(p + 16'd4);
      end
      nb = (wc == 5'd0) ? 32 : 32 - int'(wc);
      push(K_CLR, w, pal, hp, 8'h00);
      ghi = 8'(hi + 8'(zo));
      chi = 8'(cb + 8'(zo));
      for (int k = 0; k < nb; k++) begin
        a  = 16'({ghi, lo} + k);
        px = mem[a];
        if (IND_EN && ind) px = mem[{chi, px}];
        push(K_LAT, w, pal, hp, px);
      end
    end
    push(K_DONE, 1'b0, 3'd0, 8'h00, 8'h00);
  endtask

  task automatic do_start(input logic [15:0] dl, input logic [3:0] zo,
                          input logic [7:0] cb);
    @(posedge clk_sys);
    #1;
    dl_addr = dl;
    zone_offset = zo;
    charbase = cb;
    start = 1'b1;
    @(posedge clk_sys);
    #1;
    start = 1'b0;
  endtask

  task automatic run_zone(input string name, input logic [15:0] dl,
                          input logic [3:0] zo, input logic [7:0] cb,
                          input bit mid_start);
    int d0;
    int n;
    d0 = done_cnt;
    do_start(dl, zo, cb);
    if (mid_start) begin
      repeat (15) @(posedge clk_sys);
      #1;
      dl_addr = 16'h7777;
      start = 1'b1;
      @(posedge clk_sys);
      #1;
      start = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && n < 6000) begin
      @(posedge clk_sys);
      n++;
    end
    check({name, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
    #1;
    check({name, "_idle"}, 64'({busy, done, mem_req}), 64'd0);
    check({name, "_leftover"}, 64'(q.size()), 64'd0);
    q.delete();
  endtask

  task automatic setup_t1();
    logic [15:0] p;
    p = 16'h1000;
    wr(p, 8'h00); wr(p, 8'h5E); wr(p, 8'h20); wr(p, 8'h10);
    wr(p, 8'h00); wr(p, 8'h00);
    mem[16'h2200] = 8'hAA;
    mem[16'h2201] = 8'h55;
  endtask

  task automatic expect_t1();
    push(K_CLR, 1'b0, 3'd2, 8'h10, 8'h00);
    push(K_LAT, 1'b0, 3'd2, 8'h10, 8'hAA);
    push(K_LAT, 1'b0, 3'd2, 8'h10, 8'h55);
    push(K_DONE, 1'b0, 3'd0, 8'h00, 8'h00);
  endtask

  initial begin
    logic [15:0] p;
    logic [15:0] base;
    logic [7:0]  b1;
    int          nobj;
    int          n;
    reset = 1'b1;
    start = 1'b0;
    dl_addr = '0;
    zone_offset = '0;
    charbase = '0;
    rand_wait = 1'b0;
    abort_arm = 1'b0;
    abort_addr = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset_outputs",
          64'({mem_req, mem_addr, hpos, palette, pixels, wm, latch_byte,
               clear_hpos, busy, done, aborted}), 64'd0);
    reset = 1'b0;

    setup_t1();
    expect_t1();
    run_zone("basic4", 16'h1000, 4'd2, 8'h00, 1'b0);

    p = 16'h1200;
    wr(p, 8'h34); wr(p, 8'hC0); wr(p, 8'h30); wr(p, 8'hE0); wr(p, 8'h80);
    wr(p, 8'h00); wr(p, 8'h5F); wr(p, 8'h20); wr(p, 8'h10);
    wr(p, 8'h00); wr(p, 8'h00);
    for (int k = 0; k < 32; k++) mem[16'h3034 + k] = 8'(k * 7 + 1);
    mem[16'h2000] = 8'h9D;
    push(K_CLR, 1'b1, 3'd7, 8'h80, 8'h00);
    for (int k = 0; k < 32; k++) push(K_LAT, 1'b1, 3'd7, 8'h80, 8'(k * 7 + 1));
    push(K_CLR, 1'b1, 3'd2, 8'h10, 8'h00);
    push(K_LAT, 1'b1, 3'd2, 8'h10, 8'h9D);
    push(K_DONE, 1'b0, 3'd0, 8'h00, 8'h00);
    run_zone("ext32", 16'h1200, 4'd0, 8'h00, 1'b1);

    p = 16'h1300;
    wr(p, 8'h10); wr(p, 8'h60); wr(p, 8'h25); wr(p, 8'h3F); wr(p, 8'h44);
    wr(p, 8'h00); wr(p, 8'h00);
    mem[16'h2510] = 8'h05;
    mem[16'h4005] = 8'hC3;
    push(K_CLR, 1'b0, 3'd1, 8'h44, 8'h00);
    push(K_LAT, 1'b0, 3'd1, 8'h44, IND_EN ? 8'hC3 : 8'h05);
    push(K_DONE, 1'b0, 3'd0, 8'h00, 8'h00);
    run_zone("indirect", 16'h1300, 4'd0, 8'h40, 1'b0);

    p = 16'h1400;
    wr(p, 8'hFF); wr(p, 8'h5E); wr(p, 8'hFF); wr(p, 8'h20);
    wr(p, 8'h00); wr(p, 8'h00);
    mem[16'hFFFF] = 8'h11;
    mem[16'h0000] = 8'h22;
    push(K_CLR, 1'b0, 3'd2, 8'h20, 8'h00);
    push(K_LAT, 1'b0, 3'd2, 8'h20, 8'h11);
    push(K_LAT, 1'b0, 3'd2, 8'h20, 8'h22);
    push(K_DONE, 1'b0, 3'd0, 8'h00, 8'h00);
    run_zone("gfx_wrap", 16'h1400, 4'd0, 8'h00, 1'b0);

    p = 16'hFFFD;
    wr(p, 8'h00); wr(p, 8'h5F); wr(p, 8'h21); wr(p, 8'h30);
    wr(p, 8'h00); wr(p, 8'h00);
    push(K_CLR, 1'b0, 3'd2, 8'h30, 8'h00);
    push(K_LAT, 1'b0, 3'd2, 8'h30, 8'hAA);
    push(K_DONE, 1'b0, 3'd0, 8'h00, 8'h00);
    run_zone("dl_wrap", 16'hFFFD, 4'd1, 8'h00, 1'b0);

    abort_addr = 16'h2200;
    abort_arm = 1'b1;
    push(K_CLR, 1'b0, 3'd2, 8'h10, 8'h00);
    push(K_DONE, 1'b0, 3'd0, 8'h00, 8'h01);
    run_zone("abort", 16'h1000, 4'd2, 8'h00, 1'b0);
    check("abort_to_done", 64'(done_cyc - abort_cyc), 64'd1);
    check("aborted_sticky", 64'(aborted), 64'd1);

    model_zone(16'h1200, 4'd0, 8'h00);
    n = lat_cnt;
    do_start(16'h1200, 4'd0, 8'h00);
    for (int c = 0; c < 500 && lat_cnt < n + 5; c++) @(posedge clk_sys);
    check("mid_object_reached", 64'(lat_cnt >= n + 5), 64'd1);
    #1;
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    check("reset_mid_object",
          64'({mem_req, mem_addr, hpos, palette, pixels, wm, latch_byte,
               clear_hpos, busy, done, aborted}), 64'd0);
    q.delete();
    reset = 1'b0;
    expect_t1();
    run_zone("restart", 16'h1000, 4'd2, 8'h00, 1'b0);

    rand_wait = 1'b1;
    for (int r = 0; r < 6; r++) begin
      base = 16'($urandom);
      p = base;
      nobj = $urandom_range(1, 4);
      for (int o = 0; o < nobj; o++) begin
        if ($urandom_range(0, 1) == 1) begin
          b1 = {1'($urandom), 1'b1, 1'($urandom), 5'd0};
          wr(p, 8'($urandom)); wr(p, b1); wr(p, 8'($urandom));
          wr(p, 8'($urandom)); wr(p, 8'($urandom));
        end else begin
          b1 = 8'($urandom);
          if (b1[4:0] == 5'd0) b1[0] = 1'b1;
          wr(p, 8'($urandom)); wr(p, b1); wr(p, 8'($urandom));
          wr(p, 8'($urandom));
        end
      end
      wr(p, 8'($urandom));
      wr(p, {1'($urandom), 7'd0});
      zone_offset = 4'($urandom);
      charbase = 8'($urandom);
      model_zone(base, zone_offset, charbase);
      run_zone("random", base, zone_offset, charbase, r == 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
